neuron_accumulator: RTL and testbench

//   Accumulates one neuron's dot product for the autoencoder datapath.

---
 rtl/neuron_accumulator_pkg.sv | 27 ++
 rtl/neuron_accumulator_sat_add16.sv | 33 +++
 rtl/neuron_accumulator.sv | 169 ++++++++++++++++
 tb/tb_neuron_accumulator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// neuron_accumulator_pkg
//   Shared definitions for the neuron accumulator and its saturating adder.
//   Holds the default datapath widths, the saturation limits, and the
//   accumulator FSM state type. Later bias/residual stages import the same
//   package, so these values stay the same across those blocks.
// ---------------------------------------------------------------------------
package neuron_accumulator_pkg;

   // Default datapath geometry: signed Q8.8 operands.
   localparam int ACC_DATA_W    = 16;
   localparam int ACC_FRAC_W    = 8;
   localparam int ACC_MAX_TERMS = 64;
   localparam int ACC_CNT_W     = $clog2(ACC_MAX_TERMS) + 1;

   // Clamp values used when a 16-bit signed sum leaves its range.
   localparam logic [15:0] SAT_MAX = 16'h7FFF;
   localparam logic [15:0] SAT_MIN = 16'h8000;

   // Accumulator FSM states (2-bit encoding).
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_e;

endpackage

// File: rtl/neuron_accumulator_sat_add16.sv
// ---------------------------------------------------------------------------
// neuron_accumulator_sat_add16
//   Combinational 16-bit signed saturating adder.
//   Ports:
//     a_i, b_i : signed 16-bit operands
//     sum_o    : a_i + b_i, clamped to 0x7FFF / 0x8000
//     ovf_o    : high when the result was clamped
// ---------------------------------------------------------------------------
module neuron_accumulator_sat_add16
   import neuron_accumulator_pkg::*;
(
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] sum_o,
   output logic        ovf_o
);

   logic [16:0] wideSum;

   // Sign-extend both operands to 17 bits. If the two top bits of the sum
   // disagree, the true result does not fit in 16 bits. In that case bit 16
   // holds the real sign and selects which limit to clamp to.
   always_comb begin
      wideSum = {a_i[15], a_i} + {b_i[15], b_i};
      sum_o   = wideSum[15:0];
      ovf_o   = 1'b0;
      if (wideSum[16] != wideSum[15]) begin
         ovf_o = 1'b1;
         sum_o = wideSum[16] ? SAT_MIN : SAT_MAX;
      end
   end

endmodule

// File: rtl/neuron_accumulator.sv
// ---------------------------------------------------------------------------
// neuron_accumulator
//   Accumulates one neuron's dot product. The accumulator is preloaded with a
//   bias, then sums cfg_num_terms signed Q8.8 products with saturating
//   addition. One result is returned per operation over a valid/ready
//   handshake.
//   Ports:
//     clk, rst_n      : clock (rising edge) and synchronous active-low reset
//     start           : begin an operation (only honoured in IDLE)
//     bias_in         : initial accumulator value, latched on start
//     cfg_num_terms   : product count, latched on start, clamped to MAX_TERMS
//     in_valid/in_ready/in_data    : product stream input
//     out_valid/out_ready/out_data : result output
//     busy            : high whenever the FSM is not in IDLE
//     ovf_flag        : sticky saturation indicator for the current operation
//   Build option:
//     ACC_RELU_EN     : when defined, a negative result is presented as 0
// ---------------------------------------------------------------------------
module neuron_accumulator
   import neuron_accumulator_pkg::*;
#(
   parameter int DATA_W    = ACC_DATA_W,
   parameter int MAX_TERMS = ACC_MAX_TERMS,
   parameter int CNT_W     = ACC_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] bias_in,
   input  logic [CNT_W-1:0]  cfg_num_terms,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              ovf_flag
);

   acc_state_e        state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              ovf_q, ovf_d;

   logic [CNT_W-1:0]  numClamped;
   logic [DATA_W-1:0] sumVal;
   logic              sumOvf;
   logic              accept;
   logic              lastAccept;

   // Presentation of a finished sum. The optional ReLU only changes what is
   // shown on out_data. The stored sum and the overflow flag are not affected.
   function automatic logic [DATA_W-1:0] outView(input logic [DATA_W-1:0] v);
`ifdef ACC_RELU_EN
      return v[DATA_W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   neuron_accumulator_sat_add16 uSatAdd (
      .a_i   (acc_q),
      .b_i   (in_data),
      .sum_o (sumVal),
      .ovf_o (sumOvf)
   );

   // A request above MAX_TERMS is clamped. Otherwise cnt could never reach
   // num-1 within the supported range.
   assign numClamped = (cfg_num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS)
                                                           : cfg_num_terms;
   assign accept     = in_valid && in_ready_q;
   assign lastAccept = accept && (cnt_q == num_q - 1'b1);

   // Next-state logic. in_ready, out_valid and out_data are computed one cycle
   // early so that all three come straight from flops. out_valid therefore
   // rises in the cycle right after the final accept, or right after a
   // zero-term start.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      num_d       = num_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      ovf_d       = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d = bias_in;
               cnt_d = '0;
               num_d = numClamped;
               ovf_d = 1'b0;
               if (numClamped == '0) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = outView(bias_in);
               end else begin
                  state_d    = ACCUM;
                  in_ready_d = 1'b1;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_d = sumVal;
               cnt_d = cnt_q + 1'b1;
               if (sumOvf) begin
                  ovf_d = 1'b1;
               end
               if (lastAccept) begin
                  state_d     = DONE;
                  in_ready_d  = 1'b0;
                  out_valid_d = 1'b1;
                  out_data_d  = outView(sumVal);
               end
            end
         end
         DONE: begin
            // start is not examined in this state, so a start that arrives in
            // the same cycle as the output handshake is ignored.
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset aborts any operation in progress and clears
   // every output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         num_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         num_q       <= num_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign ovf_flag  = ovf_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_accumulator.sv
// ---------------------------------------------------------------------------
// tb_neuron_accumulator
//   Self-checking bench for neuron_accumulator. A table of operations is
//   driven through the DUT and the expected results are queued as each start
//   is issued. Hand-written sequences cover output back-pressure with a start
//   pulse during the hold, term-count clamping, and reset in the middle of an
//   operation.
// ---------------------------------------------------------------------------
module tb_neuron_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] bias_in;
   logic [6:0]  cfg_num_terms;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;
   logic        ovf_flag;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [15:0] data;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [15:0] bias;
      logic [6:0]  cfg;
      int          nTerms;
      logic [15:0] t0, t1, t2, t3;
      int          gap;
      logic [15:0] expData;
      logic        expOvf;
   } vec_t;

   exp_t        sbQueue[$];
   logic [15:0] termBuf [0:127];
   vec_t        vecs [8];

   neuron_accumulator dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .bias_in       (bias_in),
      .cfg_num_terms (cfg_num_terms),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .busy          (busy),
      .ovf_flag      (ovf_flag)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Expected presentation of a raw sum for the current build option.
   function automatic logic [15:0] reluExp(input logic [15:0] v);
`ifdef ACC_RELU_EN
      return v[15] ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   function automatic vec_t mkVec(input logic [15:0] bias, input logic [6:0] cfg,
                                  input int n, input logic [15:0] t0, input logic [15:0] t1,
                                  input logic [15:0] t2, input logic [15:0] t3, input int gap,
                                  input logic [15:0] expData, input logic expOvf);
      vec_t v;
      v.bias = bias; v.cfg = cfg; v.nTerms = n;
      v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3;
      v.gap = gap; v.expData = expData; v.expOvf = expOvf;
      return v;
   endfunction

   // One compared value. Reports a FAIL line on disagreement.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t)",
                  name, actual, expected, $time);
      end
   endtask

   // Advance to just after the next rising edge. Outputs are sampled and
   // inputs are changed here, away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one product after 'gap' idle cycles and wait (bounded) until it
   // is accepted.
   task automatic feedTerm(input logic [15:0] d, input int gap);
      int waitCnt;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_data  = 16'($urandom);
         tick();
      end
      in_valid = 1'b1;
      in_data  = d;
      waitCnt  = 0;
      while (!in_ready && waitCnt < 20) begin
         tick();
         waitCnt++;
      end
      if (!in_ready) begin
         checkOutput("inReadyTimeout", 32'(in_ready), 32'h1);
      end else begin
         tick();
      end
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   // Start one operation, queue its expected result, and feed termBuf.
   task automatic applyStimulus(input logic [15:0] bias, input logic [6:0] cfg,
                                input int nTerms, input int gap, input exp_t exp);
      checkOutput("busyBeforeStart", 32'(busy), 32'h0);
      // Junk on the product port while idle must not be taken.
      in_valid      = 1'b1;
      in_data       = 16'($urandom);
      checkOutput("inReadyIdle", 32'(in_ready), 32'h0);
      start         = 1'b1;
      bias_in       = bias;
      cfg_num_terms = cfg;
      sbQueue.push_back(exp);
      tick();
      start         = 1'b0;
      in_valid      = 1'b0;
      bias_in       = 16'($urandom);
      cfg_num_terms = 7'($urandom);
      checkOutput("busyAfterStart", 32'(busy), 32'h1);
      for (int i = 0; i < nTerms; i++) begin
         feedTerm(termBuf[i], gap);
      end
      checkOutput("inReadyAfterLast", 32'(in_ready), 32'h0);
   endtask

   // Collect one result. out_valid must be high immediately after the final
   // accept. The result may be held for some cycles (with start pulses that
   // must be ignored) before it is popped from the scoreboard and compared.
   task automatic collectResult(input int holdCycles, input bit pulseStart);
      exp_t        exp;
      logic [15:0] want;
      int          waitCnt;
      checkOutput("outValidLatency", 32'(out_valid), 32'h1);
      waitCnt = 0;
      while (!out_valid && waitCnt < 100) begin
         tick();
         waitCnt++;
      end
      if (!out_valid) begin
         checkOutput("outValidTimeout", 32'(out_valid), 32'h1);
      end
      if (sbQueue.size() == 0) begin
         checkOutput("scoreboardEmpty", 32'(sbQueue.size()), 32'h1);
         return;
      end
      exp  = sbQueue.pop_front();
      want = reluExp(exp.data);
      for (int h = 0; h < holdCycles; h++) begin
         out_ready     = 1'b0;
         start         = pulseStart;
         bias_in       = 16'($urandom);
         cfg_num_terms = 7'd1;
         checkOutput("holdValid", 32'(out_valid), 32'h1);
         checkOutput("holdData", 32'(out_data), 32'(want));
         tick();
      end
      out_ready = 1'b1;
      start     = pulseStart;
      checkOutput("outData", 32'(out_data), 32'(want));
      checkOutput("ovfFlag", 32'(ovf_flag), 32'(exp.ovf));
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      checkOutput("outValidDrop", 32'(out_valid), 32'h0);
      checkOutput("busyIdle", 32'(busy), 32'h0);
      tick();
      checkOutput("stillIdle", 32'(busy), 32'h0);
   endtask

   // Main test sequence.
   initial begin
      exp_t e;
      rst_n         = 1'b0;
      start         = 1'b0;
      bias_in       = 16'h0;
      cfg_num_terms = 7'h0;
      in_valid      = 1'b0;
      in_data       = 16'h0;
      out_ready     = 1'b0;
      repeat (3) tick();
      checkOutput("rstInReady", 32'(in_ready), 32'h0);
      checkOutput("rstOutValid", 32'(out_valid), 32'h0);
      checkOutput("rstOutData", 32'(out_data), 32'h0);
      checkOutput("rstBusy", 32'(busy), 32'h0);
      checkOutput("rstOvf", 32'(ovf_flag), 32'h0);
      rst_n = 1'b1;
      tick();

      vecs[0] = mkVec(16'h0100, 7'd3, 3, 16'h0080, 16'h0040, 16'hFFC0, 16'h0, 0, 16'h0180, 1'b0);
      vecs[1] = mkVec(16'h7F00, 7'd1, 1, 16'h0200, 16'h0, 16'h0, 16'h0, 0, 16'h7FFF, 1'b1);
      vecs[2] = mkVec(16'h8100, 7'd1, 1, 16'hFE00, 16'h0, 16'h0, 16'h0, 0, 16'h8000, 1'b1);
      vecs[3] = mkVec(16'h0A00, 7'd0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h0A00, 1'b0);
      vecs[4] = mkVec(16'h0000, 7'd1, 1, 16'hFF00, 16'h0, 16'h0, 16'h0, 0, 16'hFF00, 1'b0);
      vecs[5] = mkVec(16'h1000, 7'd4, 4, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1, 16'h1400, 1'b0);
      vecs[6] = mkVec(16'h7F00, 7'd2, 2, 16'h0200, 16'hFF00, 16'h0, 16'h0, 0, 16'h7EFF, 1'b1);
      vecs[7] = mkVec(16'h8000, 7'd2, 2, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 2, 16'h8001, 1'b1);

      for (int v = 0; v < 8; v++) begin
         termBuf[0] = vecs[v].t0;
         termBuf[1] = vecs[v].t1;
         termBuf[2] = vecs[v].t2;
         termBuf[3] = vecs[v].t3;
         e.data = vecs[v].expData;
         e.ovf  = vecs[v].expOvf;
         applyStimulus(vecs[v].bias, vecs[v].cfg, vecs[v].nTerms, vecs[v].gap, e);
         collectResult(0, 1'b0);
      end

      // Back-pressure: result held for 5 cycles while start is pulsed.
      termBuf[0] = 16'h0300;
      termBuf[1] = 16'h0400;
      e.data = 16'h0800;
      e.ovf  = 1'b0;
      applyStimulus(16'h0100, 7'd2, 2, 0, e);
      collectResult(5, 1'b1);

      // Term count above the maximum is clamped to 64 products.
      for (int i = 0; i < 64; i++) termBuf[i] = 16'h0001;
      e.data = 16'h0040;
      e.ovf  = 1'b0;
      applyStimulus(16'h0000, 7'd100, 64, 0, e);
      collectResult(0, 1'b0);

      // Reset in the middle of an operation, after two accepts with gaps.
      start         = 1'b1;
      bias_in       = 16'h7F00;
      cfg_num_terms = 7'd4;
      tick();
      start = 1'b0;
      feedTerm(16'h0200, 2);
      feedTerm(16'h0100, 2);
      checkOutput("midOpOvf", 32'(ovf_flag), 32'h1);
      checkOutput("midOpBusy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      tick();
      checkOutput("abortInReady", 32'(in_ready), 32'h0);
      checkOutput("abortOutValid", 32'(out_valid), 32'h0);
      checkOutput("abortOutData", 32'(out_data), 32'h0);
      checkOutput("abortBusy", 32'(busy), 32'h0);
      checkOutput("abortOvf", 32'(ovf_flag), 32'h0);
      rst_n = 1'b1;
      tick();
      termBuf[0] = 16'h0100;
      e.data = 16'h0100;
      e.ovf  = 1'b0;
      applyStimulus(16'h0000, 7'd1, 1, 0, e);
      collectResult(0, 1'b0);

      checkOutput("scoreboardDrained", 32'(sbQueue.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
